// File: rtl/program_loader.sv
// Streams opcode/reg/data field sets into packed instruction words written to consecutive
// program-memory addresses. Define LOADER_NOP_PAD_EN to append a NOP word after the last beat.
module program_loader #(
    parameter int unsigned ADDR_WIDTH      = 5,
    parameter int unsigned REG_BIT_CNT     = 3,
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned COMBINED_DATA   = ADDR_WIDTH + REG_BIT_CNT + DATA_WIDTH,
    parameter int unsigned PROG_ADDR_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [PROG_ADDR_WIDTH-1:0] base_addr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_WIDTH-1:0]      in_opcode,
    input  logic [REG_BIT_CNT-1:0]     in_reg,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       in_last,
    output logic                       mem_we,
    output logic [PROG_ADDR_WIDTH-1:0] mem_addr,
    output logic [COMBINED_DATA-1:0]   mem_wdata,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic [PROG_ADDR_WIDTH:0]   count
);

`ifdef LOADER_NOP_PAD_EN
    typedef enum logic [1:0] {StIdle, StLoad, StPad, StErr} state_e;
    localparam logic [ADDR_WIDTH-1:0] NopOpcode = '0;
`else
    typedef enum logic [1:0] {StIdle, StLoad, StErr} state_e;
`endif

    localparam logic [PROG_ADDR_WIDTH-1:0] PtrMax   = '1;
    localparam logic [PROG_ADDR_WIDTH:0]   CountMax = {1'b1, {PROG_ADDR_WIDTH{1'b0}}};

    state_e                       state_q, state_d;
    logic [PROG_ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [PROG_ADDR_WIDTH:0]     count_q, count_d, count_inc;
    logic                         overflow_q, overflow_d;
    logic                         we_q, we_d;
    logic [PROG_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [COMBINED_DATA-1:0]     wdata_q, wdata_d;
    logic                         done_q, done_d;

    assign count_inc = (count_q == CountMax) ? count_q : count_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        // start takes priority over any beat offered on the same edge
        if (start) begin
            state_d    = StLoad;
            ptr_d      = base_addr;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                StLoad: begin
                    if (in_valid) begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = {in_opcode, in_reg, in_data};
                        count_d = count_inc;
                        if (in_last) begin
`ifdef LOADER_NOP_PAD_EN
                            if (ptr_q == PtrMax) begin
                                state_d    = StErr;
                                overflow_d = 1'b1;
                            end else begin
                                state_d = StPad;
                                ptr_d   = ptr_q + 1'b1;
                            end
`else
                            state_d = StIdle;
                            done_d  = 1'b1;
                            if (ptr_q != PtrMax) ptr_d = ptr_q + 1'b1;
`endif
                        end else if (ptr_q == PtrMax) begin
                            state_d    = StErr;
                            overflow_d = 1'b1;
                        end else begin
                            ptr_d = ptr_q + 1'b1;
                        end
                    end
                end
`ifdef LOADER_NOP_PAD_EN
                StPad: begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = {NopOpcode, {(COMBINED_DATA - ADDR_WIDTH){1'b0}}};
                    count_d = count_inc;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
        end
    end

    assign in_ready  = (state_q == StLoad);
    assign busy      = (state_q != StIdle) && (state_q != StErr);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign count     = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus random traffic, each cycle
// compared against a session-level model of the loader.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_ready, in_last;
    logic [7:0]  base_addr, mem_addr;
    logic [4:0]  in_opcode;
    logic [2:0]  in_reg;
    logic [15:0] in_data;
    logic        mem_we, busy, done, overflow;
    logic [23:0] mem_wdata;
    logic [8:0]  count;

    int errors = 0;
    int checks = 0;

    // session model
    bit m_active = 0;
    bit m_ovf    = 0;
    int m_ptr    = 0;
    int m_cnt    = 0;

    program_loader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_reg(in_reg),
        .in_data(in_data), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply the current inputs for one edge, then check every output against the model.
    task automatic step();
        bit          e_we   = 0;
        bit          e_done = 0;
        int          e_addr = 0;
        logic [23:0] e_word = '0;
        if (rst) begin
            m_active = 0; m_ovf = 0; m_ptr = 0; m_cnt = 0;
        end else if (start) begin
            m_active = 1; m_ovf = 0; m_ptr = int'(base_addr); m_cnt = 0;
        end else if (m_active && in_valid) begin
            e_we   = 1;
            e_addr = m_ptr;
            e_word = {in_opcode, in_reg, in_data};
            m_cnt  = (m_cnt < 256) ? m_cnt + 1 : 256;
            if (in_last) begin
                m_active = 0;
                e_done   = 1;
            end else if (m_ptr == 255) begin
                m_active = 0;
                m_ovf    = 1;
            end else begin
                m_ptr++;
            end
        end
        @(posedge clk);
        #1;
        chk("in_ready", 32'(in_ready), 32'(m_active));
        chk("busy", 32'(busy), 32'(m_active));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("done", 32'(done), 32'(e_done));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("count", 32'(count), 32'(m_cnt));
        if (e_we) begin
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(e_word));
        end
    endtask

    task automatic beat(input logic [4:0] op, input logic [2:0] r, input logic [15:0] d,
                        input logic last);
        in_valid = 1; in_opcode = op; in_reg = r; in_data = d; in_last = last;
    endtask

    task automatic idle_in();
        in_valid = 0; in_last = 0; start = 0;
    endtask

    initial begin
        rst = 1; start = 0; base_addr = '0; in_valid = 0; in_last = 0;
        in_opcode = '0; in_reg = '0; in_data = '0;
        step();
        step();
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_wdata", 32'(mem_wdata), 32'h0);
        rst = 0;

        // basic load, separate beats
        start = 1; base_addr = 8'h10; step(); start = 0;
        beat(5'h03, 3'd2, 16'h1234, 0); step();
        chk("basic_w1", 32'(mem_wdata), 32'h1A1234);
        idle_in(); step();
        beat(5'h05, 3'd7, 16'hFFFF, 0); step();
        chk("basic_w2", 32'(mem_wdata), 32'h2FFFFF);
        idle_in(); step();
        beat(5'h01, 3'd0, 16'h0000, 1); step();
        chk("basic_w3", 32'(mem_wdata), 32'h080000);
        chk("basic_a3", 32'(mem_addr), 32'h12);
        chk("basic_cnt", 32'(count), 32'd3);
        idle_in(); step();

        // back-to-back
        start = 1; base_addr = 8'h30; step(); start = 0;
        for (int i = 0; i < 4; i++) begin
            beat(5'(i + 1), 3'(i), 16'(i * 16'h1111), logic'(i == 3));
            step();
        end
        idle_in(); step();

        // overflow at top of memory
        start = 1; base_addr = 8'hFE; step(); start = 0;
        for (int i = 0; i < 3; i++) begin
            beat(5'h1F, 3'd5, 16'hA5A5 + 16'(i), 0);
            step();
        end
        chk("ovf_flag", 32'(overflow), 32'h1);
        idle_in(); step(); step();

        // abort: restart mid-session, with a beat offered on the same edge
        start = 1; base_addr = 8'h20; step(); start = 0;
        beat(5'h02, 3'd1, 16'hBEEF, 0); step();
        start = 1; base_addr = 8'h40; step(); start = 0;
        beat(5'h04, 3'd3, 16'hCAFE, 1); step();
        chk("abort_addr", 32'(mem_addr), 32'h40);
        chk("abort_cnt", 32'(count), 32'd1);
        idle_in(); step();

        // reset on the edge a beat is accepted
        start = 1; base_addr = 8'h50; step(); start = 0;
        beat(5'h06, 3'd6, 16'h0F0F, 0); rst = 1; step();
        rst = 0; idle_in(); step();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            start     = ($urandom_range(0, 24) == 0);
            base_addr = ($urandom_range(0, 3) == 0) ? 8'hF8 + 8'($urandom_range(0, 7))
                                                    : 8'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 9) == 0);
            in_opcode = 5'($urandom);
            in_reg    = 3'($urandom);
            in_data   = 16'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
